// File: rtl/sel_pipe_pkg.sv
// rtl/sel_pipe_pkg.sv - shared constants and helpers for the sel_pipe select pipeline
package sel_pipe_pkg;

    // Value loaded into the data field for out-of-range selects and on reset.
    localparam int unsigned DEFAULT_DATA = 0;

    // Ceiling log2, never below 1 so a selector port always has at least one bit.
    function automatic int clog2_min1(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/sel_pipe_skid.sv
// rtl/sel_pipe_skid.sv - one-entry skid register; upstream ready comes only from a flop
module sel_pipe_skid #(
    parameter int W = 9
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] s_tdata_i,
    input  logic         s_tvalid_i,
    output logic         s_tready_o,
    output logic [W-1:0] m_tdata_o,
    output logic         m_tvalid_o,
    input  logic         m_tready_i
);
    logic         full_q, full_d;
    logic [W-1:0] data_q, data_d;

    // Items pass straight through while empty; the skid only captures on a stall.
    always_comb begin
        full_d = full_q;
        data_d = data_q;
        if (full_q) begin
            if (m_tready_i) full_d = 1'b0;
        end else if (s_tvalid_i && !m_tready_i) begin
            full_d = 1'b1;
            data_d = s_tdata_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
        end
    end

    assign s_tready_o = !full_q;
    assign m_tvalid_o = full_q || s_tvalid_i;
    assign m_tdata_o  = full_q ? data_q : s_tdata_i;

endmodule

// File: rtl/sel_pipe.sv
// rtl/sel_pipe.sv - N-way select retimed over STAGES valid/ready stages
// Optional SEL_PIPE_SKID_EN adds a skid register so in_ready no longer depends on out_ready.
module sel_pipe
    import sel_pipe_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int N      = 2,
    parameter int STAGES = 1,
    parameter int SEL_W  = clog2_min1(N)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [SEL_W-1:0]   in_sel,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_err,
    output logic               out_valid,
    input  logic               out_ready
);
    typedef struct packed {
        logic             err;
        logic [WIDTH-1:0] data;
    } sel_err_t;

    sel_err_t          sel_d;
    logic [STAGES:0]   adv;
    logic [STAGES-1:0] v_all;
    sel_err_t          d_all [STAGES];
    sel_err_t          tail;
    logic              tail_ready;

    always_comb begin
        sel_d      = '0;
        sel_d.data = WIDTH'(DEFAULT_DATA);
        if (int'(in_sel) < N) begin
            sel_d.data = in_data[int'(in_sel)*WIDTH +: WIDTH];
        end else begin
            sel_d.err = 1'b1;
        end
    end

    // A stage advances when it is empty or the stage after it is advancing.
    always_comb begin
        adv         = '0;
        adv[STAGES] = tail_ready;
        for (int s = STAGES - 1; s >= 0; s--) begin
            adv[s] = !v_all[s] || adv[s+1];
        end
    end

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        logic     v_q;
        sel_err_t d_q;
        logic     src_v;
        sel_err_t src_d;

        if (s == 0) begin : g_head
            assign src_v = in_valid;
            assign src_d = sel_d;
        end else begin : g_body
            assign src_v = v_all[s-1];
            assign src_d = d_all[s-1];
        end

        // Data only loads alongside a valid item, so idle inputs never reach the regs.
        always_ff @(posedge clk) begin
            if (rst) begin
                v_q <= 1'b0;
                d_q <= '0;
            end else if (adv[s]) begin
                v_q <= src_v;
                if (src_v) d_q <= src_d;
            end
        end

        assign v_all[s] = v_q;
        assign d_all[s] = d_q;
    end

    assign tail     = d_all[STAGES-1];
    assign in_ready = adv[0];

`ifdef SEL_PIPE_SKID_EN
    sel_err_t out_pkt;

    sel_pipe_skid #(
        .W (WIDTH + 1)
    ) u_skid (
        .clk        (clk),
        .rst        (rst),
        .s_tdata_i  (tail),
        .s_tvalid_i (v_all[STAGES-1]),
        .s_tready_o (tail_ready),
        .m_tdata_o  (out_pkt),
        .m_tvalid_o (out_valid),
        .m_tready_i (out_ready)
    );

    assign out_data = out_pkt.data;
    assign out_err  = out_pkt.err;
`else
    assign tail_ready = out_ready;
    assign out_valid  = v_all[STAGES-1];
    assign out_data   = tail.data;
    assign out_err    = tail.err;
`endif

endmodule

// File: tb/tb_sel_pipe.sv
// tb/tb_sel_pipe.sv - randomized and directed checks of sel_pipe against a queue model
module tb_sel_pipe;
    localparam int STAGES_A = 3;
    localparam int STAGES_B = 2;
`ifdef SEL_PIPE_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif
    localparam int CAP_A = SKID ? STAGES_A + 1 : STAGES_A;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // DUT A: N=3 (non power of two), STAGES=3
    logic [1:0]  a_in_sel = '0;
    logic [23:0] a_in_data = '0;
    logic        a_in_valid = 1'b0, a_in_ready, a_out_err, a_out_valid, a_out_ready = 1'b1;
    logic [7:0]  a_out_data;

    // DUT B: N=4, STAGES=2
    logic [1:0]  b_in_sel = '0;
    logic [31:0] b_in_data = '0;
    logic        b_in_valid = 1'b0, b_in_ready, b_out_err, b_out_valid, b_out_ready = 1'b1;
    logic [7:0]  b_out_data;

    sel_pipe #(.WIDTH(8), .N(3), .STAGES(STAGES_A)) u_dut_a (
        .clk(clk), .rst(rst), .in_sel(a_in_sel), .in_data(a_in_data),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .out_data(a_out_data),
        .out_err(a_out_err), .out_valid(a_out_valid), .out_ready(a_out_ready)
    );

    sel_pipe #(.WIDTH(8), .N(4), .STAGES(STAGES_B)) u_dut_b (
        .clk(clk), .rst(rst), .in_sel(b_in_sel), .in_data(b_in_data),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .out_data(b_out_data),
        .out_err(b_out_err), .out_valid(b_out_valid), .out_ready(b_out_ready)
    );

`ifdef SEL_PIPE_SKID_EN
    // DUT C: N=2, STAGES=1, exercised only when the skid is built in
    logic        c_in_sel = 1'b0;
    logic [15:0] c_in_data = '0;
    logic        c_in_valid = 1'b0, c_in_ready, c_out_err, c_out_valid, c_out_ready = 1'b1;
    logic [7:0]  c_out_data;

    sel_pipe #(.WIDTH(8), .N(2), .STAGES(1)) u_dut_c (
        .clk(clk), .rst(rst), .in_sel(c_in_sel), .in_data(c_in_data),
        .in_valid(c_in_valid), .in_ready(c_in_ready), .out_data(c_out_data),
        .out_err(c_out_err), .out_valid(c_out_valid), .out_ready(c_out_ready)
    );
`endif

    // Reference select: {err, data}; channel k is byte k of the flattened input.
    function automatic logic [8:0] ref_sel(input int sel, input int n, input logic [31:0] d);
        if (sel >= n) return 9'h100;
        return {1'b0, 8'((d >> (8 * sel)) & 32'hff)};
    endfunction

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        n_checks++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_a_valid got=%b want=0", a_out_valid); end
        n_checks++; if ({a_out_err, a_out_data} !== 9'h000) begin n_fail++; $display("FAIL reset_a_data got=%h want=000", {a_out_err, a_out_data}); end
        n_checks++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_a_ready got=%b want=1", a_in_ready); end
        n_checks++; if (b_out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_b_valid got=%b want=0", b_out_valid); end
        n_checks++; if (b_in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_b_ready got=%b want=1", b_in_ready); end
    endtask

    task automatic test_select_n4();
        @(negedge clk);
        b_in_data = 32'h44332211; b_in_sel = 2'd2; b_in_valid = 1'b1; b_out_ready = 1'b1;
        #1;
        n_checks++; if (b_in_ready !== 1'b1) begin n_fail++; $display("FAIL sel4_ready got=%b want=1", b_in_ready); end
        @(negedge clk);
        b_in_valid = 1'b0; b_in_data = '0;
        #1;
        n_checks++; if (b_out_valid !== 1'b0) begin n_fail++; $display("FAIL sel4_early got=%b want=0", b_out_valid); end
        @(negedge clk);
        #1;
        n_checks++; if (b_out_valid !== 1'b1) begin n_fail++; $display("FAIL sel4_valid got=%b want=1", b_out_valid); end
        n_checks++; if ({b_out_err, b_out_data} !== 9'h033) begin n_fail++; $display("FAIL sel4_data got=%h want=033", {b_out_err, b_out_data}); end
        @(negedge clk);
        #1;
        n_checks++; if (b_out_valid !== 1'b0) begin n_fail++; $display("FAIL sel4_drained got=%b want=0", b_out_valid); end
    endtask

    task automatic test_out_of_range();
        @(negedge clk);
        a_in_data = 24'($urandom); a_in_sel = 2'd3; a_in_valid = 1'b1; a_out_ready = 1'b1;
        for (int c = 1; c <= STAGES_A; c++) begin
            @(negedge clk);
            a_in_valid = 1'b0;
            #1;
            n_checks++;
            if (a_out_valid !== (c == STAGES_A)) begin
                n_fail++; $display("FAIL oor_valid cyc=%0d got=%b want=%b", c, a_out_valid, (c == STAGES_A));
            end
        end
        n_checks++; if ({a_out_err, a_out_data} !== 9'h100) begin n_fail++; $display("FAIL oor_data got=%h want=100", {a_out_err, a_out_data}); end
    endtask

    // mode 0: 1,0,0,1 ready pattern; mode 1: random everything; mode 2: fill then in+out together
    task automatic test_stream(input int n_items, input int mode);
        logic [8:0] exp_q[$];
        int         t_q[$];
        int         cyc, sent, got;
        logic       exp_v, exp_r;
        cyc = 0; sent = 0; got = 0;
        @(negedge clk);
        while (got < n_items && cyc < 2000) begin
            a_in_valid  = (sent < n_items) && (mode == 1 ? 1'($urandom_range(0, 1)) : 1'b1);
            a_in_sel    = (mode == 1) ? 2'($urandom_range(0, 3)) : 2'(sent % 3);
            a_in_data   = 24'($urandom);
            case (mode)
                0:       a_out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
                1:       a_out_ready = 1'($urandom_range(0, 1));
                default: a_out_ready = (cyc > CAP_A);
            endcase
            #1;
            exp_v = (exp_q.size() > 0) && (cyc - t_q[0] >= STAGES_A);
            exp_r = SKID ? (exp_q.size() < STAGES_A + 1) : ((exp_q.size() < STAGES_A) || a_out_ready);
            n_checks++;
            if (a_out_valid !== exp_v) begin
                n_fail++; $display("FAIL stream%0d_valid cyc=%0d got=%b want=%b", mode, cyc, a_out_valid, exp_v);
            end
            n_checks++;
            if (a_in_ready !== exp_r) begin
                n_fail++; $display("FAIL stream%0d_ready cyc=%0d got=%b want=%b", mode, cyc, a_in_ready, exp_r);
            end
            if (exp_v) begin
                n_checks++;
                if ({a_out_err, a_out_data} !== exp_q[0]) begin
                    n_fail++; $display("FAIL stream%0d_data cyc=%0d got=%h want=%h", mode, cyc, {a_out_err, a_out_data}, exp_q[0]);
                end
            end
            if (a_in_valid && exp_r) begin
                exp_q.push_back(ref_sel(int'(a_in_sel), 3, {8'h00, a_in_data}));
                t_q.push_back(cyc);
                sent++;
            end
            if (exp_v && a_out_ready) begin
                void'(exp_q.pop_front());
                void'(t_q.pop_front());
                got++;
            end
            @(negedge clk);
            cyc++;
        end
        n_checks++;
        if (got != n_items) begin
            n_fail++; $display("FAIL stream%0d_timeout got=%0d want=%0d", mode, got, n_items);
        end
        a_in_valid = 1'b0; a_out_ready = 1'b1;
    endtask

    task automatic test_reset_midstream();
        @(negedge clk);
        a_out_ready = 1'b0; a_in_valid = 1'b1; a_in_sel = 2'd1;
        for (int k = 0; k < 2; k++) begin
            a_in_data = 24'($urandom) | 24'h00ff00;
            #1;
            n_checks++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_accept k=%0d got=%b want=1", k, a_in_ready); end
            @(negedge clk);
        end
        a_in_valid = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_checks++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid got=%b want=0", a_out_valid); end
        n_checks++; if ({a_out_err, a_out_data} !== 9'h000) begin n_fail++; $display("FAIL rstmid_data got=%h want=000", {a_out_err, a_out_data}); end
        n_checks++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_ready got=%b want=1", a_in_ready); end
        a_out_ready = 1'b1;
        for (int c = 0; c < STAGES_A + 2; c++) begin
            @(negedge clk);
            #1;
            n_checks++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_stale cyc=%0d got=%b want=0", c, a_out_valid); end
        end
    endtask

`ifdef SEL_PIPE_SKID_EN
    task automatic test_skid();
        logic [8:0] exp_q[$];
        int acc;
        acc = 0;
        @(negedge clk);
        c_out_ready = 1'b0; c_in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            c_in_sel  = 1'(c % 2);
            c_in_data = 16'($urandom);
            #1;
            if (c_in_ready) begin
                acc++;
                exp_q.push_back(ref_sel(int'(c_in_sel), 2, {16'h0000, c_in_data}));
            end
            @(negedge clk);
        end
        c_in_valid = 1'b0;
        #1;
        n_checks++; if (acc != 2) begin n_fail++; $display("FAIL skid_capacity got=%0d want=2", acc); end
        n_checks++; if (c_in_ready !== 1'b0) begin n_fail++; $display("FAIL skid_full_ready got=%b want=0", c_in_ready); end
        n_checks++; if (c_out_valid !== 1'b1 || {c_out_err, c_out_data} !== exp_q[0]) begin
            n_fail++; $display("FAIL skid_first got=%b/%h want=1/%h", c_out_valid, {c_out_err, c_out_data}, exp_q[0]);
        end
        c_out_ready = 1'b1;
        #1;
        n_checks++; if (c_in_ready !== 1'b0) begin n_fail++; $display("FAIL skid_comb_path got=%b want=0", c_in_ready); end
        @(negedge clk);
        #1;
        n_checks++; if (exp_q.size() < 2 || c_out_valid !== 1'b1 || {c_out_err, c_out_data} !== exp_q[exp_q.size()-1]) begin
            n_fail++; $display("FAIL skid_second got=%b/%h", c_out_valid, {c_out_err, c_out_data});
        end
    endtask
`endif

    initial begin
        test_reset();
        test_select_n4();
        test_out_of_range();
        test_stream(10, 0);
        test_stream(40, 1);
        test_stream(12, 2);
        test_reset_midstream();
`ifdef SEL_PIPE_SKID_EN
        test_skid();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
